tick_sched_ctrl: RTL
====================

// Module: tick_sched_ctrl
// PURPOSE
// - Rate scheduler/controller for the clock-divider datapath: one shared base counter chain
//   produces single-cycle enable ticks (display refresh, 2 Hz, 1 Hz) plus a blink level.
// - A run-control FSM gates which ticks reach downstream counters and display logic.
// - Sits between the board clock and the counter/display blocks; all consumers stay on clk.
// PARAMETERS
// - DIV_REFRESH  10000       clk cycles per tick_refresh; must be >= 2.
// - DIV_2HZ      50000000    clk cycles per tick_2hz; must be >= 2.
// - CNT_W        26          width of the slow counter; must satisfy 2^CNT_W > DIV_2HZ.
// PORTS
// - clk          in   1  system clock; all logic on posedge.
// - rst          in   1  synchronous, active-low reset (0 = reset).
// - go           in   1  single-cycle pulse; toggles RUN<->PAUSE, or IDLE->RUN.
// - clr          in   1  single-cycle pulse; returns to IDLE.
// - adjust       in   1  level; held high forces ADJUST.
// - tick_refresh out  1  1-cycle pulse every DIV_REFRESH clks, all states.
// - tick_2hz     out  1  1-cycle pulse every DIV_2HZ clks, in RUN and ADJUST only.
// - tick_1hz     out  1  1-cycle pulse on every 2nd gated 2 Hz event, in RUN only.
// - blink        out  1  toggles on each 2 Hz event in ADJUST; 0 elsewhere.
// - running      out  1  1 iff state == RUN.
// - state        out  2  00 IDLE, 01 RUN, 10 PAUSE, 11 ADJUST.
// BEHAVIOUR
// - Reset (rst==0 at posedge): state=IDLE; refresh counter, slow counter and half-flag = 0;
//   all outputs 0. Reset mid-operation discards all progress the same cycle.
// - Refresh counter: 0..DIV_REFRESH-1, wraps; tick_refresh=1 for the cycle after it holds
//   DIV_REFRESH-1 (registered). Free-running outside reset regardless of state.
// - Slow counter: 0..DIV_2HZ-1, wraps; advances only in RUN and ADJUST; holds in PAUSE;
//   cleared in IDLE. The 2 Hz event is the wrap; tick_2hz registered, 1 cycle after.
// - half-flag toggles on each 2 Hz event in RUN; tick_1hz fires on the event where
//   half-flag was 1. First tick_1hz after RUN entry from IDLE = 2*DIV_2HZ+1 clks after go.
// - Transitions, priority clr > adjust > go, evaluated every cycle:
//   - clr=1: any -> IDLE (clears slow counter and half-flag).
//   - adjust=1: any non-ADJUST -> ADJUST; entry clears slow counter, blink=0.
//   - ADJUST with adjust=0 -> PAUSE (slow counter, half-flag cleared on exit).
//   - go: IDLE->RUN, RUN->PAUSE, PAUSE->RUN; ignored in ADJUST.
// - Simultaneous: state change and counter wrap in the same cycle -> the tick is produced
//   only if the *current* (pre-transition) state permits it. clr with a wrap: tick suppressed.
// - PAUSE->RUN resumes slow counter from held value; no phase loss, no extra tick.
// - running/state are registered and change the cycle after the causing input.
// - Outputs are pure registers; no combinational path input->output.
// CONFIGURATION
// - TICK_SCHED_BLINK_EN defined: blink implemented as above.
// - TICK_SCHED_BLINK_EN undefined: blink tied to 0, toggle flop omitted; all else unchanged.
// TESTING (DIV_REFRESH=4, DIV_2HZ=10 unless stated)
// - Reset: rst=0 3 cycles -> all outputs 0, state=00; release -> tick_refresh at cycles 4,8,12.
// - go pulse at t0 -> state=01 at t0+1; tick_2hz at t0+11,t0+21; tick_1hz only at t0+21.
// - go at RUN slow count 6 -> PAUSE, no tick_2hz for 30 cycles; go again -> next tick_2hz
//   4 cycles later; tick_refresh continues uninterrupted throughout.
// - adjust high from RUN -> state=11 next cycle; tick_2hz every 10, tick_1hz never, blink
//   toggles 0->1->0 on each; adjust low -> state=10, blink=0.
// - clr and adjust in same cycle while RUN -> state=00; clr coinciding with slow wrap ->
//   no tick_2hz; rst=0 mid-RUN -> all zero next cycle.
// - Build without TICK_SCHED_BLINK_EN, repeat ADJUST test -> blink stays 0, ticks identical.

Source files
------------

// File: rtl/tick_sched_ctrl_if.sv
// tick_sched_ctrl_if
//   Control/tick bundle between the rate scheduler and its consumers.
//   master : drives go/clr/adjust, observes ticks and run status.
//   slave  : the scheduler; samples controls, drives ticks and status.
//   go, clr       single-cycle control pulses
//   adjust        level, held high to stay in ADJUST
//   tick_refresh  display refresh enable
//   tick_2hz      gated 2 Hz enable
//   tick_1hz      gated 1 Hz enable
//   blink         adjust-mode blink level
//   running       1 iff state is RUN
//   state         00 IDLE, 01 RUN, 10 PAUSE, 11 ADJUST
interface tick_sched_ctrl_if;
  logic       go;
  logic       clr;
  logic       adjust;
  logic       tick_refresh;
  logic       tick_2hz;
  logic       tick_1hz;
  logic       blink;
  logic       running;
  logic [1:0] state;

  modport master (
    output go, clr, adjust,
    input  tick_refresh, tick_2hz, tick_1hz, blink, running, state
  );

  modport slave (
    input  go, clr, adjust,
    output tick_refresh, tick_2hz, tick_1hz, blink, running, state
  );
endinterface

// File: rtl/tick_sched_ctrl.sv
// tick_sched_ctrl
//   Rate scheduler for the clock-divider datapath. A free-running refresh
//   counter produces tick_refresh; a gated slow counter produces the 2 Hz
//   event, from which tick_1hz (RUN) and blink (ADJUST) are derived. A
//   run-control FSM (IDLE/RUN/PAUSE/ADJUST) decides which ticks pass.
//   Ports:
//     clk  system clock, posedge
//     rst  synchronous active-low reset
//     bus  tick_sched_ctrl_if.slave (controls in, ticks/status out)
//   Build option: define TICK_SCHED_BLINK_EN to implement blink; otherwise
//   blink is tied low and its flop is omitted.
//   All outputs are registers; ticks reflect the pre-transition state.
module tick_sched_ctrl #(
  parameter int DIV_REFRESH = 10000,
  parameter int DIV_2HZ     = 50000000,
  parameter int CNT_W       = 26
) (
  input  logic               clk,
  input  logic               rst,
  tick_sched_ctrl_if.slave   bus
);
  typedef enum logic [1:0] {IDLE = 2'b00, RUN = 2'b01, PAUSE = 2'b10, ADJ = 2'b11} state_t;

  localparam int RW = (DIV_REFRESH > 1) ? $clog2(DIV_REFRESH) : 1;
  localparam logic [RW-1:0]    REF_MAX  = RW'(DIV_REFRESH - 1);
  localparam logic [CNT_W-1:0] SLOW_MAX = CNT_W'(DIV_2HZ - 1);

  state_t           st, st_nxt;
  logic [RW-1:0]    ref_cnt;
  logic [CNT_W-1:0] slow_cnt, slow_nxt;
  logic             half, half_nxt;
  logic             t_ref, t_2hz, t_1hz, run_q;
  logic             t_2hz_nxt, t_1hz_nxt;
  logic             wrap, ticking, adj_entry, adj_exit;

  assign wrap      = (slow_cnt == SLOW_MAX);
  assign ticking   = (st == RUN) || (st == ADJ);
  assign adj_entry = (st != ADJ) && (st_nxt == ADJ);
  assign adj_exit  = (st == ADJ) && (st_nxt != ADJ);

  // state register
  always_ff @(posedge clk) begin
    if (!rst) st <= IDLE;
    else      st <= st_nxt;
  end

  // next state: clr > adjust > go
  always_comb begin
    st_nxt = st;
    if (bus.clr)         st_nxt = IDLE;
    else if (bus.adjust) st_nxt = ADJ;
    else begin
      case (st)
        IDLE:    if (bus.go) st_nxt = RUN;
        RUN:     if (bus.go) st_nxt = PAUSE;
        PAUSE:   if (bus.go) st_nxt = RUN;
        default: st_nxt = PAUSE;
      endcase
    end
  end

  // output/datapath next values; gating uses the current state so a tick
  // coinciding with a transition still follows the state it was earned in
  always_comb begin
    slow_nxt  = slow_cnt;
    half_nxt  = half;
    t_2hz_nxt = wrap && ticking && !bus.clr;
    t_1hz_nxt = wrap && (st == RUN) && half && !bus.clr;
    if (bus.clr || adj_entry || adj_exit || st == IDLE) slow_nxt = '0;
    else if (ticking) slow_nxt = wrap ? '0 : slow_cnt + 1'b1;
    if (bus.clr || adj_exit || st == IDLE) half_nxt = 1'b0;
    else if (st == RUN && wrap)            half_nxt = ~half;
  end

  // refresh chain runs in every state
  always_ff @(posedge clk) begin
    if (!rst) begin
      ref_cnt <= '0;
      t_ref   <= 1'b0;
    end else begin
      ref_cnt <= (ref_cnt == REF_MAX) ? '0 : ref_cnt + 1'b1;
      t_ref   <= (ref_cnt == REF_MAX);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      slow_cnt <= '0;
      half     <= 1'b0;
      t_2hz    <= 1'b0;
      t_1hz    <= 1'b0;
      run_q    <= 1'b0;
    end else begin
      slow_cnt <= slow_nxt;
      half     <= half_nxt;
      t_2hz    <= t_2hz_nxt;
      t_1hz    <= t_1hz_nxt;
      run_q    <= (st_nxt == RUN);
    end
  end

`ifdef TICK_SCHED_BLINK_EN
  logic blink_q;
  // blink only survives while staying in ADJUST; entry and exit force 0
  always_ff @(posedge clk) begin
    if (!rst)                            blink_q <= 1'b0;
    else if (st == ADJ && st_nxt == ADJ) blink_q <= blink_q ^ (wrap && !bus.clr);
    else                                 blink_q <= 1'b0;
  end
  assign bus.blink = blink_q;
`else
  assign bus.blink = 1'b0;
`endif

  assign bus.tick_refresh = t_ref;
  assign bus.tick_2hz     = t_2hz;
  assign bus.tick_1hz     = t_1hz;
  assign bus.running      = run_q;
  assign bus.state        = st;
endmodule
